// File: rtl/wb_shared_bus.sv
// wb_shared_bus: Wishbone B3 shared-bus interconnect, up to 4 masters and 8 slaves.
//
// One master owns the bus at a time. Ownership is granted round-robin and held for
// the whole cyc burst, so locked read-modify-write sequences stay atomic. The owner's
// address is decoded against per-slave mask/base pairs; the lowest matching slave wins.
// A decode miss is answered by a registered one-cycle error.
//
// Optional feature macro: WB_BUS_TIMEOUT_EN
//   When defined, a 16-bit watchdog converts a transfer stalled for TIMEOUT_CYCLES
//   cycles into a one-cycle bus error (the slave strobe is dropped for that cycle).
//   When undefined, no watchdog is built and a stalled slave holds the bus.
//
// Ports:
//   clk_i, rst_n_i              bus clock, asynchronous active-low reset
//   m_cyc_i/m_stb_i/m_we_i      per-master cycle, strobe, write enable
//   m_sel_i/m_adr_i/m_dat_i     packed per-master byte selects, address, write data
//   m_dat_o                     read data, broadcast to every master
//   m_ack_o/m_err_o/m_rty_o     per-master terminations (only the owner sees non-zero)
//   s_cyc_o/s_stb_o             per-slave cycle and strobe
//   s_we_o/s_sel_o/s_adr_o/s_dat_o  broadcast owner request (zero while idle)
//   s_dat_i                     packed per-slave read data
//   s_ack_i/s_err_i/s_rty_i     per-slave terminations
//   gnt_o                       one-hot current owner

module wb_shared_bus #(
    parameter int unsigned NUM_MASTERS = 2,
    parameter int unsigned NUM_SLAVES  = 4,
    parameter int unsigned AW          = 32,
    parameter int unsigned DW          = 32,
    parameter logic [NUM_SLAVES*AW-1:0] SLV_BASE = {NUM_SLAVES{32'h0}},
    parameter logic [NUM_SLAVES*AW-1:0] SLV_MASK = {NUM_SLAVES{32'hF000_0000}},
    parameter int unsigned TIMEOUT_CYCLES = 255,
    localparam int unsigned SW = DW / 8
) (
    input  logic                      clk_i,
    input  logic                      rst_n_i,
    input  logic [NUM_MASTERS-1:0]    m_cyc_i,
    input  logic [NUM_MASTERS-1:0]    m_stb_i,
    input  logic [NUM_MASTERS-1:0]    m_we_i,
    input  logic [NUM_MASTERS*SW-1:0] m_sel_i,
    input  logic [NUM_MASTERS*AW-1:0] m_adr_i,
    input  logic [NUM_MASTERS*DW-1:0] m_dat_i,
    output logic [NUM_MASTERS*DW-1:0] m_dat_o,
    output logic [NUM_MASTERS-1:0]    m_ack_o,
    output logic [NUM_MASTERS-1:0]    m_err_o,
    output logic [NUM_MASTERS-1:0]    m_rty_o,
    output logic [NUM_SLAVES-1:0]     s_cyc_o,
    output logic [NUM_SLAVES-1:0]     s_stb_o,
    output logic                      s_we_o,
    output logic [SW-1:0]             s_sel_o,
    output logic [AW-1:0]             s_adr_o,
    output logic [DW-1:0]             s_dat_o,
    input  logic [NUM_SLAVES*DW-1:0]  s_dat_i,
    input  logic [NUM_SLAVES-1:0]     s_ack_i,
    input  logic [NUM_SLAVES-1:0]     s_err_i,
    input  logic [NUM_SLAVES-1:0]     s_rty_i,
    output logic [NUM_MASTERS-1:0]    gnt_o
);

    localparam int unsigned MW  = (NUM_MASTERS > 1) ? $clog2(NUM_MASTERS) : 1;
    localparam int unsigned SIW = (NUM_SLAVES > 1) ? $clog2(NUM_SLAVES) : 1;

    typedef enum logic [0:0] {StIdle, StBusy} state_e;

    state_e          state_q, state_d;
    logic [MW-1:0]   owner_q, owner_d;
    logic [MW-1:0]   last_q, last_d;
    logic            err_q, err_d;

    logic            busy;
    logic            own_cyc, own_stb, own_we;
    logic [AW-1:0]   own_adr;
    logic [DW-1:0]   own_dat;
    logic [SW-1:0]   own_sel;
    logic [NUM_SLAVES-1:0] match;
    logic            hit;
    logic [SIW-1:0]  slv_idx;
    logic            slv_active;
    logic            sel_ack, sel_err, sel_rty;
    logic [DW-1:0]   sel_dat;
    logic            wd_fire;

    // First requester after 'base', wrapping; 'base' itself is considered last.
    function automatic logic [MW-1:0] rr_pick(input logic [NUM_MASTERS-1:0] req,
                                              input logic [MW-1:0] base);
        logic        found;
        int unsigned idx;
        rr_pick = base;
        found   = 1'b0;
        for (int unsigned k = 1; k <= NUM_MASTERS; k++) begin
            idx = (32'(base) + k) % NUM_MASTERS;
            if (!found && req[idx]) begin
                rr_pick = MW'(idx);
                found   = 1'b1;
            end
        end
    endfunction

    // Owner request mux and address decode.
    always_comb begin
        busy    = (state_q == StBusy);
        own_cyc = busy & m_cyc_i[owner_q];
        own_stb = own_cyc & m_stb_i[owner_q];
        own_we  = busy & m_we_i[owner_q];
        own_adr = busy ? m_adr_i[int'(owner_q)*AW +: AW] : '0;
        own_dat = busy ? m_dat_i[int'(owner_q)*DW +: DW] : '0;
        own_sel = busy ? m_sel_i[int'(owner_q)*SW +: SW] : '0;

        match = '0;
        for (int i = 0; i < int'(NUM_SLAVES); i++) begin
            match[i] = ((own_adr & SLV_MASK[i*AW +: AW]) ==
                        (SLV_BASE[i*AW +: AW] & SLV_MASK[i*AW +: AW]));
        end
        hit = |match;

        // Scan downwards so the lowest matching index is left in slv_idx.
        slv_idx = '0;
        for (int i = int'(NUM_SLAVES) - 1; i >= 0; i--) begin
            if (match[i]) slv_idx = SIW'(i);
        end

        slv_active = own_cyc & hit;
        sel_ack    = slv_active & s_ack_i[slv_idx];
        sel_err    = slv_active & s_err_i[slv_idx];
        sel_rty    = slv_active & s_rty_i[slv_idx];
        sel_dat    = slv_active ? s_dat_i[int'(slv_idx)*DW +: DW] : '0;
    end

`ifdef WB_BUS_TIMEOUT_EN
    localparam logic [15:0] WdLimit = 16'(TIMEOUT_CYCLES);

    logic [15:0] wd_cnt_q, wd_cnt_d;
    logic        sel_term;

    // An owner change always passes through a cycle with the old owner's cyc low,
    // so clearing on stb low also covers owner changes.
    always_comb begin
        sel_term = sel_ack | sel_err | sel_rty | err_q;
        wd_fire  = own_stb & (wd_cnt_q == WdLimit);
        wd_cnt_d = '0;
        if (own_stb && !sel_term && !wd_fire) begin
            wd_cnt_d = wd_cnt_q + 16'd1;
        end
    end

    always_ff @(posedge clk_i or negedge rst_n_i) begin
        if (!rst_n_i) begin
            wd_cnt_q <= '0;
        end else begin
            wd_cnt_q <= wd_cnt_d;
        end
    end
`else
    logic unused_timeout;
    assign unused_timeout = ^16'(TIMEOUT_CYCLES);
    assign wd_fire        = 1'b0;
`endif

    // Arbitration FSM next state.
    always_comb begin
        state_d = state_q;
        owner_d = owner_q;
        last_d  = last_q;
        err_d   = own_stb & ~hit & ~err_q;
        unique case (state_q)
            StIdle: begin
                if (|m_cyc_i) begin
                    owner_d = rr_pick(m_cyc_i, last_q);
                    state_d = StBusy;
                end
            end
            StBusy: begin
                if (!m_cyc_i[owner_q]) begin
                    last_d = owner_q;
                    if (|m_cyc_i) begin
                        owner_d = rr_pick(m_cyc_i, owner_q);
                    end else begin
                        state_d = StIdle;
                    end
                end
            end
            default: state_d = StIdle;
        endcase
    end

    always_ff @(posedge clk_i or negedge rst_n_i) begin
        if (!rst_n_i) begin
            state_q <= StIdle;
            owner_q <= MW'(NUM_MASTERS - 1);
            last_q  <= MW'(NUM_MASTERS - 1);
            err_q   <= 1'b0;
        end else begin
            state_q <= state_d;
            owner_q <= owner_d;
            last_q  <= last_d;
            err_q   <= err_d;
        end
    end

    // Bus outputs.
    always_comb begin
        s_cyc_o = '0;
        s_stb_o = '0;
        if (slv_active) begin
            s_cyc_o[slv_idx] = 1'b1;
            s_stb_o[slv_idx] = own_stb & ~wd_fire;
        end
        s_we_o  = own_we;
        s_sel_o = own_sel;
        s_adr_o = own_adr;
        s_dat_o = own_dat;

        gnt_o   = '0;
        m_ack_o = '0;
        m_err_o = '0;
        m_rty_o = '0;
        if (busy) begin
            gnt_o[owner_q]   = 1'b1;
            m_ack_o[owner_q] = sel_ack;
            m_err_o[owner_q] = sel_err | err_q | wd_fire;
            m_rty_o[owner_q] = sel_rty;
        end
        m_dat_o = {NUM_MASTERS{sel_dat}};
    end

endmodule

// File: tb/tb_wb_shared_bus.sv
module tb_wb_shared_bus;

    logic         clk = 1'b0;
    logic         rst_n = 1'b0;
    logic [1:0]   m_cyc, m_stb, m_we;
    logic [7:0]   m_sel;
    logic [63:0]  m_adr, m_dat_w, m_dat_r;
    logic [1:0]   m_ack, m_err, m_rty;
    logic [3:0]   s_cyc, s_stb;
    logic         s_we;
    logic [3:0]   s_sel;
    logic [31:0]  s_adr, s_dat_w;
    logic [127:0] s_dat_r;
    logic [3:0]   s_ack, s_err, s_rty;
    logic [1:0]   gnt;
    logic [3:0]   stall;
    logic [31:0]  wr_data [4];

    int total = 0;
    int bad   = 0;
    int exp_last;

    logic [31:0] t_adr [2];
    logic [31:0] t_dat [2];
    logic [3:0]  t_sel [2];
    logic        t_we  [2];

    wb_shared_bus #(
        .NUM_MASTERS(2),
        .NUM_SLAVES(4),
        .AW(32),
        .DW(32),
        .SLV_BASE({32'h3000_0000, 32'h2000_0000, 32'h1000_0000, 32'h0000_0000}),
        .SLV_MASK({4{32'hF000_0000}}),
        .TIMEOUT_CYCLES(10)
    ) dut (
        .clk_i(clk), .rst_n_i(rst_n),
        .m_cyc_i(m_cyc), .m_stb_i(m_stb), .m_we_i(m_we), .m_sel_i(m_sel),
        .m_adr_i(m_adr), .m_dat_i(m_dat_w), .m_dat_o(m_dat_r),
        .m_ack_o(m_ack), .m_err_o(m_err), .m_rty_o(m_rty),
        .s_cyc_o(s_cyc), .s_stb_o(s_stb), .s_we_o(s_we), .s_sel_o(s_sel),
        .s_adr_o(s_adr), .s_dat_o(s_dat_w), .s_dat_i(s_dat_r),
        .s_ack_i(s_ack), .s_err_i(s_err), .s_rty_i(s_rty),
        .gnt_o(gnt)
    );

    always #5 clk = ~clk;

    // Read data each slave returns for a given address.
    function automatic logic [31:0] slave_data(input int i, input logic [31:0] a);
        if (i == 3 && a == 32'h3000_0004) return 32'hDEADBEEF;
        return a ^ (32'h1111_1111 * 32'(i + 1));
    endfunction

    // Address map: top nibble 0..3 selects that slave, anything else is unmapped.
    function automatic int decode(input logic [31:0] a);
        if (a[31:28] < 4'd4) return int'(a[31:28]);
        return -1;
    endfunction

    function automatic int rr_next(input logic [1:0] req, input int last);
        for (int k = 1; k <= 2; k++) begin
            if (req[(last + k) % 2]) return (last + k) % 2;
        end
        return -1;
    endfunction

    // Behavioural slaves: zero-wait ack unless stalled.
    assign s_ack = s_stb & ~stall;
    assign s_err = 4'b0;
    assign s_rty = 4'b0;
    always_comb begin
        s_dat_r = '0;
        for (int i = 0; i < 4; i++) s_dat_r[i*32 +: 32] = slave_data(i, s_adr);
    end
    always_ff @(posedge clk) begin
        for (int i = 0; i < 4; i++) begin
            if (s_stb[i] && s_ack[i] && s_we) wr_data[i] <= s_dat_w;
        end
    end

    task automatic chk(input string tag, input logic [63:0] obs, input logic [63:0] exp);
        total++;
        assert (obs === exp) else begin
            bad++;
            $error("FAIL %s observed=%h expected=%h", tag, obs, exp);
        end
    endtask

    task automatic tick();
        @(posedge clk);
        #1;
    endtask

    task automatic settle();
        #2;
    endtask

    task automatic check_quiet(input string tag);
        chk({tag, "_gnt"}, 64'(gnt), 64'h0);
        chk({tag, "_scyc"}, 64'(s_cyc), 64'h0);
        chk({tag, "_sstb"}, 64'(s_stb), 64'h0);
        chk({tag, "_term"}, 64'({m_ack, m_err, m_rty}), 64'h0);
        chk({tag, "_mdat"}, m_dat_r, 64'h0);
        chk({tag, "_bcast"}, 64'({s_we, s_sel, s_adr}), 64'h0);
        chk({tag, "_sdat"}, 64'(s_dat_w), 64'h0);
    endtask

    // Every master in req raises a single transfer (from t_*) at once; the bus
    // is expected to serve them in round-robin order and then go idle.
    task automatic do_group(input logic [1:0] req, input string tag);
        logic [1:0] pend;
        int own;
        int slv;
        pend = req;
        for (int m = 0; m < 2; m++) begin
            if (req[m]) begin
                m_cyc[m] = 1'b1;
                m_stb[m] = 1'b1;
                m_we[m]  = t_we[m];
                m_adr[m*32 +: 32]  = t_adr[m];
                m_dat_w[m*32 +: 32] = t_dat[m];
                m_sel[m*4 +: 4] = t_sel[m];
            end
        end
        tick();
        while (pend != 2'b00) begin
            own = rr_next(pend, exp_last);
            slv = decode(t_adr[own]);
            settle();
            chk({tag, "_gnt"}, 64'(gnt), 64'(2'b01 << own));
            if (slv >= 0) begin
                chk({tag, "_stb"}, 64'(s_stb), 64'(4'b0001 << slv));
                chk({tag, "_ack"}, 64'(m_ack), 64'(2'b01 << own));
                chk({tag, "_errrty"}, 64'({m_err, m_rty}), 64'h0);
                chk({tag, "_adr"}, 64'(s_adr), 64'(t_adr[own]));
                chk({tag, "_we"}, 64'(s_we), 64'(t_we[own]));
                chk({tag, "_sel"}, 64'(s_sel), 64'(t_sel[own]));
                if (t_we[own]) begin
                    chk({tag, "_wdat"}, 64'(s_dat_w), 64'(t_dat[own]));
                end else begin
                    chk({tag, "_rdat"}, m_dat_r, {2{slave_data(slv, t_adr[own])}});
                end
                tick();
                if (t_we[own]) chk({tag, "_wmem"}, 64'(wr_data[slv]), 64'(t_dat[own]));
            end else begin
                chk({tag, "_miss_stb"}, 64'(s_stb), 64'h0);
                chk({tag, "_miss_err0"}, 64'(m_err), 64'h0);
                tick();
                settle();
                chk({tag, "_miss_err1"}, 64'(m_err), 64'(2'b01 << own));
                chk({tag, "_miss_stb1"}, 64'(s_stb), 64'h0);
                tick();
            end
            m_cyc[own] = 1'b0;
            m_stb[own] = 1'b0;
            m_we[own]  = 1'b0;
            settle();
            chk({tag, "_rel_gnt"}, 64'(gnt), 64'(2'b01 << own));
            chk({tag, "_rel_stb"}, 64'(s_stb), 64'h0);
            chk({tag, "_rel_term"}, 64'({m_ack, m_err}), 64'h0);
            tick();
            exp_last = own;
            pend[own] = 1'b0;
        end
        settle();
        chk({tag, "_idle_gnt"}, 64'(gnt), 64'h0);
    endtask

    initial begin
        #200000;
        $display("FAIL global_timeout");
        $fatal(1, "bench timed out");
    end

    initial begin
        logic [3:0] nibs [5];
        nibs = '{4'h0, 4'h1, 4'h2, 4'h3, 4'h9};
        stall = 4'b0;
        m_cyc = 2'b11; m_stb = 2'b11; m_we = 2'b11;
        m_sel = 8'hFF; m_adr = 64'h1000_0000_1000_0000; m_dat_w = '1;

        // Outputs must stay zero under reset even with requests pending.
        #12;
        check_quiet("reset");
        m_cyc = 2'b00; m_stb = 2'b00; m_we = 2'b00;
        m_sel = '0; m_adr = '0; m_dat_w = '0;
        tick();
        rst_n = 1'b1;
        exp_last = 1;
        tick();
        settle();
        check_quiet("idle");

        // Simultaneous requests: master 0 first, master 1 right after.
        t_adr[0] = 32'h0000_0100; t_we[0] = 1'b0; t_dat[0] = 32'h0; t_sel[0] = 4'hF;
        t_adr[1] = 32'h1000_0200; t_we[1] = 1'b1; t_dat[1] = 32'hA5A5_0001; t_sel[1] = 4'h3;
        do_group(2'b11, "both");

        // Read from slave 3.
        t_adr[1] = 32'h3000_0004; t_we[1] = 1'b0; t_sel[1] = 4'hF;
        do_group(2'b10, "s3read");
        t_adr[0] = 32'h3000_0004; t_we[0] = 1'b0;
        m_cyc[0] = 1'b1; m_stb[0] = 1'b1; m_adr[31:0] = 32'h3000_0004; m_sel[3:0] = 4'hF;
        tick(); settle();
        chk("beef_stb", 64'(s_stb), 64'h8);
        chk("beef_dat", m_dat_r, {2{32'hDEADBEEF}});
        tick();
        m_cyc[0] = 1'b0; m_stb[0] = 1'b0;
        tick(); tick();
        exp_last = 0;

        // Unmapped address.
        t_adr[0] = 32'h9000_0000; t_we[0] = 1'b0;
        do_group(2'b01, "unmapped");

        // Locked read-then-write burst by master 1 while master 0 waits.
        m_cyc[1] = 1'b1; m_stb[1] = 1'b1; m_we[1] = 1'b0;
        m_adr[63:32] = 32'h2000_0010; m_sel[7:4] = 4'hF;
        tick(); settle();
        chk("lock_gnt1", 64'(gnt), 64'h2);
        chk("lock_rd", m_dat_r, {2{slave_data(2, 32'h2000_0010)}});
        m_cyc[0] = 1'b1; m_stb[0] = 1'b1; m_we[0] = 1'b0; m_adr[31:0] = 32'h0000_0020;
        tick();
        m_stb[1] = 1'b0;
        settle();
        chk("lock_gap_gnt", 64'(gnt), 64'h2);
        chk("lock_gap_stb", 64'(s_stb), 64'h0);
        chk("lock_gap_cyc", 64'(s_cyc), 64'h4);
        chk("lock_gap_ack", 64'(m_ack), 64'h0);
        tick();
        m_stb[1] = 1'b1; m_we[1] = 1'b1;
        m_adr[63:32] = 32'h2000_0014; m_dat_w[63:32] = 32'hCAFE_1234;
        settle();
        chk("lock_wr_gnt", 64'(gnt), 64'h2);
        chk("lock_wr_stb", 64'(s_stb), 64'h4);
        chk("lock_wr_ack", 64'(m_ack), 64'h2);
        tick();
        chk("lock_wr_mem", 64'(wr_data[2]), 64'hCAFE_1234);
        m_cyc[1] = 1'b0; m_stb[1] = 1'b0; m_we[1] = 1'b0;
        tick(); settle();
        chk("lock_hand_gnt", 64'(gnt), 64'h1);
        chk("lock_hand_stb", 64'(s_stb), 64'h1);
        chk("lock_hand_ack", 64'(m_ack), 64'h1);
        tick();
        m_cyc[0] = 1'b0; m_stb[0] = 1'b0;
        tick();
        exp_last = 0;

        // Stalled slave 1.
        stall[1] = 1'b1;
        m_cyc[0] = 1'b1; m_stb[0] = 1'b1; m_we[0] = 1'b0; m_adr[31:0] = 32'h1000_0040;
        tick();
        for (int k = 0; k < 10; k++) begin
            settle();
            chk("wd_wait_err", 64'(m_err), 64'h0);
            chk("wd_wait_stb", 64'(s_stb), 64'h2);
            tick();
        end
        settle();
`ifdef WB_BUS_TIMEOUT_EN
        chk("wd_fire_err", 64'(m_err), 64'h1);
        chk("wd_fire_stb", 64'(s_stb), 64'h0);
        tick(); settle();
        chk("wd_after_err", 64'(m_err), 64'h0);
        chk("wd_after_stb", 64'(s_stb), 64'h2);
`else
        for (int k = 0; k < 10; k++) begin
            chk("hang_err", 64'(m_err), 64'h0);
            chk("hang_stb", 64'(s_stb), 64'h2);
            tick(); settle();
        end
`endif
        m_cyc[0] = 1'b0; m_stb[0] = 1'b0;
        tick();
        stall[1] = 1'b0;
        exp_last = 0;
        settle();
        chk("wd_idle_gnt", 64'(gnt), 64'h0);
        tick();

        // Randomized groups checked against the round-robin/address-map model.
        for (int it = 0; it < 30; it++) begin
            for (int m = 0; m < 2; m++) begin
                t_adr[m] = {nibs[$urandom_range(0, 4)], 28'($urandom)};
                t_we[m]  = 1'($urandom);
                t_dat[m] = $urandom;
                t_sel[m] = 4'($urandom);
            end
            do_group(2'($urandom_range(1, 3)), "rand");
        end

        // Reset asserted mid-transfer.
        stall[1] = 1'b1;
        m_cyc[1] = 1'b1; m_stb[1] = 1'b1; m_adr[63:32] = 32'h1000_0000;
        tick(); settle();
        chk("mid_pre_stb", 64'(s_stb), 64'h2);
        rst_n = 1'b0;
        #1;
        check_quiet("midrst");
        tick();
        stall[1] = 1'b0;
        m_cyc = 2'b00; m_stb = 2'b00;
        rst_n = 1'b1;
        exp_last = 1;
        t_adr[0] = 32'h2000_0008; t_we[0] = 1'b0;
        t_adr[1] = 32'h0000_000C; t_we[1] = 1'b0;
        do_group(2'b11, "postrst");

        $display("test done: total=%0d bad=%0d", total, bad);
        $finish;
    end

endmodule
